mem_port_arbiter: RTL

- Sequences the single shared AXI memory port between three requesters:
  - instruction-cache refill read
  - data-cache refill read
  - data-cache dirty writeback
- Replaces the plain OR of the cache FSMs' start strobes with an owner-tracking FSM. That FSM issues one start pulse, steers the address, and routes completion (r_last / b_resp) back only to the owning cache FSM.
- Sits between the cache FSMs inside the control unit and the AXI master.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_watchdog.sv | 28 ++
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - state and owner encoding shared by the memory port arbiter files
package mem_arb_pkg;

   localparam logic [1:0] OWNER_NONE = 2'd0;
   localparam logic [1:0] OWNER_I_RD = 2'd1;
   localparam logic [1:0] OWNER_D_RD = 2'd2;
   localparam logic [1:0] OWNER_D_WR = 2'd3;

   // The state encoding is the owner value driven on o_owner.
   typedef enum logic [1:0] {
      IDLE = OWNER_NONE,
      RD_I = OWNER_I_RD,
      RD_D = OWNER_D_RD,
      WR_D = OWNER_D_WR
   } arb_state_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - busy-cycle watchdog; expired is high during the TIMEOUT_CYCLES-th busy cycle
module mem_arb_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic arstn,
   input  logic busy,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count;

   // count holds the busy cycles already completed, so it reads 0 in the first busy cycle
   assign expired = busy && (count == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         count <= '0;
      end else if (!busy || expired) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - owner-tracking arbiter for the shared AXI memory port
// Optional busy watchdog and o_timeout_err port under MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              arstn,
   input  logic              i_icache_rd_req,
   input  logic [ADDR_W-1:0] i_icache_rd_addr,
   input  logic              i_dcache_rd_req,
   input  logic [ADDR_W-1:0] i_dcache_rd_addr,
   input  logic              i_dcache_wr_req,
   input  logic [ADDR_W-1:0] i_dcache_wr_addr,
   input  logic              i_read_last_axi,
   input  logic              i_b_resp_axi,
   output logic              o_start_read_axi,
   output logic              o_start_write_axi,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_icache_rd_done,
   output logic              o_dcache_rd_done,
   output logic              o_dcache_wr_done,
   output logic [1:0]        o_owner,
   output logic              o_busy
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   output logic              o_timeout_err
`endif
);

   arb_state_t state;
   logic       last_was_d;
   logic       xfer_done;
   logic       abort;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   assign o_owner          = state;
   assign o_busy           = (state != IDLE);
   assign o_icache_rd_done = (state == RD_I) && i_read_last_axi;
   assign o_dcache_rd_done = (state == RD_D) && i_read_last_axi;
   assign o_dcache_wr_done = (state == WR_D) && i_b_resp_axi;
   assign xfer_done        = o_icache_rd_done || o_dcache_rd_done || o_dcache_wr_done;

`ifdef MEM_ARB_TIMEOUT_EN
   mem_arb_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .arstn   (arstn),
      .busy    (o_busy),
      .expired (abort)
   );

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         o_timeout_err <= 1'b0;
      end else if (abort) begin
         o_timeout_err <= 1'b1;
      end
   end
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state             <= IDLE;
         last_was_d        <= 1'b0;
         o_mem_addr        <= '0;
         o_start_read_axi  <= 1'b0;
         o_start_write_axi <= 1'b0;
      end else begin
         o_start_read_axi  <= 1'b0;
         o_start_write_axi <= 1'b0;
         case (state)
            IDLE: begin
               // I wins after a D grant, or whenever D has nothing pending
               if (i_icache_rd_req && (last_was_d || !(i_dcache_wr_req || i_dcache_rd_req))) begin
                  state            <= RD_I;
                  o_mem_addr       <= i_icache_rd_addr;
                  last_was_d       <= 1'b0;
                  o_start_read_axi <= 1'b1;
               end else if (i_dcache_wr_req) begin
                  state             <= WR_D;
                  o_mem_addr        <= i_dcache_wr_addr;
                  last_was_d        <= 1'b1;
                  o_start_write_axi <= 1'b1;
               end else if (i_dcache_rd_req) begin
                  state            <= RD_D;
                  o_mem_addr       <= i_dcache_rd_addr;
                  last_was_d       <= 1'b1;
                  o_start_read_axi <= 1'b1;
               end
            end
            default: begin
               if (xfer_done || abort) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
